// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO slice.
package sync_fifo_pkg;
  localparam int unsigned DEF_DWIDTH = 16;
  localparam int unsigned DEF_AWIDTH = 3;
endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array, synchronous write, asynchronous read, cleared on reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_we,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic [DWIDTH-1:0] o_rdata
);
  localparam int unsigned DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with wrap-bit pointers.
// Optional overflow/underflow ports are enabled by defining SYNC_FIFO_ERR_EN.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wren,
  input  logic              rden,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
`ifdef SYNC_FIFO_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);
  localparam logic [AWIDTH:0] PTR_ONE = {{AWIDTH{1'b0}}, 1'b1};

  logic [AWIDTH:0] r_wr_ptr;
  logic [AWIDTH:0] r_rd_ptr;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_acc;
  logic            w_rd_acc;

  // Same index with differing wrap bits means the writer is one lap ahead.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (r_wr_ptr[AWIDTH] != r_rd_ptr[AWIDTH]) &&
                    (r_wr_ptr[AWIDTH-1:0] == r_rd_ptr[AWIDTH-1:0]);
  assign w_wr_acc = wren && !w_full;
  assign w_rd_acc = rden && !w_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  sync_fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AWIDTH-1:0]),
    .i_wdata (din),
    .i_raddr (r_rd_ptr[AWIDTH-1:0]),
    .o_rdata (dout)
  );

  assign full  = w_full;
  assign empty = w_empty;

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= wren && w_full;
      r_underflow <= rden && w_empty;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table, directed corner cases, random traffic vs a queue model.
module tb_sync_fifo;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rstn;
  logic          wren;
  logic          rden;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_ERR_EN
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .wren  (wren),
    .rden  (rden),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
`ifdef SYNC_FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] q[$];

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] d;
    logic          exp_empty;
    logic          exp_full;
    logic          chk_dout;
    logic [DW-1:0] exp_dout;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of traffic; the model decides acceptance from pre-edge occupancy.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d);
    bit do_wr, do_rd, exp_ovf, exp_unf;
    wren = wr; rden = rd; din = d;
    chk("empty_pre", {31'b0, empty}, {31'b0, q.size() == 0});
    chk("full_pre", {31'b0, full}, {31'b0, q.size() == DEPTH});
    if (q.size() > 0) chk("dout_head", {16'b0, dout}, {16'b0, q[0]});
    do_rd   = rd && (q.size() > 0);
    do_wr   = wr && (q.size() < DEPTH);
    exp_ovf = wr && (q.size() == DEPTH);
    exp_unf = rd && (q.size() == 0);
    @(posedge clk); #1;
    if (do_rd) void'(q.pop_front());
    if (do_wr) q.push_back(d);
    wren = 1'b0; rden = 1'b0;
`ifdef SYNC_FIFO_ERR_EN
    chk("overflow", {31'b0, overflow}, {31'b0, exp_ovf});
    chk("underflow", {31'b0, underflow}, {31'b0, exp_unf});
`else
    if (exp_ovf && exp_unf) $display("unexpected model state");
`endif
  endtask

  task automatic drain_expect(input int n, input logic [DW-1:0] first, input int stride);
    logic [DW-1:0] e;
    e = first;
    for (int i = 0; i < n; i++) begin
      chk("drain_order", {16'b0, dout}, {16'b0, e});
      step(1'b0, 1'b1, '0);
      e = e + DW'(stride);
    end
  endtask

  initial begin
    int waited;
    logic [DW-1:0] v;
    int wr_pct;

    rstn = 1'b0; wren = 1'b0; rden = 1'b0; din = '0;
    #12;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_dout", {16'b0, dout}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;

    tbl[0] = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[1] = '{1'b1, 1'b0, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h1234};
    tbl[2] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5678};
    tbl[3] = '{1'b1, 1'b1, 16'h9ABC, 1'b0, 1'b0, 1'b1, 16'h9ABC};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
    tbl[6] = '{1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h0F0F};
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].wr, tbl[i].rd, tbl[i].d);
      chk("tbl_empty", {31'b0, empty}, {31'b0, tbl[i].exp_empty});
      chk("tbl_full", {31'b0, full}, {31'b0, tbl[i].exp_full});
      if (tbl[i].chk_dout) chk("tbl_dout", {16'b0, dout}, {16'b0, tbl[i].exp_dout});
    end

    // Asynchronous reset with three words queued.
    step(1'b1, 1'b0, 16'hAAAA);
    step(1'b1, 1'b0, 16'hBBBB);
    rstn = 1'b0; #1;
    chk("midrst_empty", {31'b0, empty}, 32'd1);
    chk("midrst_full", {31'b0, full}, 32'd0);
    chk("midrst_dout", {16'b0, dout}, 32'd0);
    q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    step(1'b1, 1'b0, 16'h1234);
    chk("postrst_dout", {16'b0, dout}, 32'h1234);
    chk("postrst_empty", {31'b0, empty}, 32'd0);
    step(1'b0, 1'b1, '0);

    for (int i = 0; i < 50; i++) begin
      v = DW'($urandom);
      step(1'b1, 1'b0, v);
      waited = 0;
      while (empty && waited < 4) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("raw_wait", {31'b0, empty}, 32'd0);
      chk("raw_dout", {16'b0, dout}, {16'b0, v});
      step(1'b0, 1'b1, '0);
      chk("raw_empty", {31'b0, empty}, 32'd1);
    end

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, ~DW'(i + 1));
    chk("fill_full", {31'b0, full}, 32'd1);
    step(1'b1, 1'b0, 16'hDEAD);
    chk("ovf_full", {31'b0, full}, 32'd1);
    drain_expect(DEPTH, 16'hFFFE, -1);
    chk("drain_empty", {31'b0, empty}, 32'd1);

    step(1'b0, 1'b1, '0);
    chk("unf_empty", {31'b0, empty}, 32'd1);
    step(1'b1, 1'b0, 16'h55AA);
    chk("unf_dout", {16'b0, dout}, 32'h55AA);
    step(1'b0, 1'b1, '0);
    chk("unf_empty2", {31'b0, empty}, 32'd1);

    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(16'h10 + i));
    step(1'b1, 1'b1, 16'h0014);
    chk("sim4_count", q.size(), 32'd4);
    drain_expect(4, 16'h0011, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(16'h20 + i));
    step(1'b1, 1'b1, 16'h0077);
    chk("simfull_full", {31'b0, full}, 32'd0);
    drain_expect(DEPTH - 1, 16'h0021, 1);
    step(1'b1, 1'b1, 16'hBEEF);
    chk("simempty_empty", {31'b0, empty}, 32'd0);
    chk("simempty_dout", {16'b0, dout}, 32'hBEEF);
    step(1'b0, 1'b1, '0);

    wr_pct = 50;
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0) wr_pct = int'($urandom_range(20, 80));
      step(($urandom_range(99) < wr_pct), ($urandom_range(99) < 50), DW'($urandom));
    end
    chk("final_empty", {31'b0, empty}, {31'b0, q.size() == 0});
    chk("final_full", {31'b0, full}, {31'b0, q.size() == DEPTH});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer of 2**AWIDTH words of DWIDTH bits. It decouples a producer and a consumer in the same clock domain and provides full and empty status. Read data is show-ahead: the oldest word is always on dout and is consumed by rden.

## Interface
- DWIDTH, default 16: data word width in bits.
- AWIDTH, default 3: address width; depth = 2**AWIDTH (default 8).
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- wren  input  1  write request; din is stored on this edge when not full.
- rden  input  1  read request; pops the head word on this edge when not empty.
- din  input  DWIDTH  write data.
- dout  output  DWIDTH  head-of-queue data, mem[rd_ptr], combinational from storage and pointer.
- full  output  1  all 2**AWIDTH entries occupied.
- empty  output  1  no entries occupied.

## Operation
- Pointers wr_ptr and rd_ptr are AWIDTH+1 bits; the low AWIDTH bits address storage, and the MSB is the wrap bit.
- Flag rules:
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and low bits equal.
  - Both flags are decoded from the registered pointers, with no other logic.
- Accepted write (wren && !full): mem[wr_ptr[AWIDTH-1:0]] <= din; wr_ptr <= wr_ptr+1.
- Accepted read (rden && !empty): rd_ptr <= rd_ptr+1. dout shows the next word after the edge.
- Write while full: ignored; no storage or pointer change.
- Read while empty: ignored; dout holds.
- Simultaneous wren and rden:
  - Neither flag set: both take effect; occupancy unchanged.
  - Full: only the read takes effect.
  - Empty: only the write takes effect.
- Pointers wrap modulo 2**(AWIDTH+1); storage index wraps modulo depth.
- Reset (rstn low, any time, including mid-operation):
  - Pointers go to 0 and all storage goes to 0.
  - Outputs: empty=1, full=0, dout=0.
  - Queued contents are lost.

## Timing
- Write-to-visibility latency: 1 edge. The word written on edge N appears on dout and deasserts empty after edge N when the queue was empty.
- Read latency: 0. dout is valid whenever empty=0, and the same word is captured by the consumer on the popping edge.
- full asserts after the edge that accepts the depth-th write. It deasserts after the first accepted read.
- empty asserts after the edge that pops the last word.
- The bench samples dout before the popping edge takes effect; that value must equal the word being popped.

## Configuration
- SYNC_FIFO_ERR_EN defined: adds two output ports.
  - overflow (1 bit): registered, high for one cycle after an edge with wren && full.
  - underflow (1 bit): registered, high for one cycle after an edge with rden && empty.
  - Both reset to 0.
- SYNC_FIFO_ERR_EN undefined: neither port nor its logic exists; all other behaviour is identical.

## Structure
- Package sync_fifo_pkg holds DEF_DWIDTH=16 and DEF_AWIDTH=3, which are the module defaults.
- One sub-module, sync_fifo_mem:
  - Parameterised register array with synchronous write port and asynchronous read port.
  - Contents reset to 0 on rstn.
- Pointer and flag logic stays in sync_fifo.

## Test plan
- Reset: hold rstn low mid-stream with 3 words queued -> empty=1, full=0, dout=0 immediately; after release, one write of 0x1234 -> dout=0x1234 and empty=0 one edge later.
- Read-after-write: 50 iterations of write random v, wait for empty=0, read -> dout==v on every pop; empty=1 after each pop.
- Fill/drain: write ~(i+1) for i=0..7 (0xFFFE..0xFFF7) -> full=1 after 8th write. Then 8 reads -> dout order 0xFFFE, 0xFFFD, ..., 0xFFF7, and empty=1 at the end.
- Overflow: when full, write 0xDEAD -> ignored; drain returns the original 8 words. With SYNC_FIFO_ERR_EN, overflow pulses for 1 cycle.
- Underflow: when empty, pulse rden -> pointers unchanged and a subsequent write/read pair works. With SYNC_FIFO_ERR_EN, underflow pulses.
- Simultaneous:
  - wren+rden with 4 words queued -> count stays 4 and order is preserved.
  - wren+rden when full -> becomes not full.
  - wren+rden when empty -> 1 word, dout=din.
  - Run more than 16 writes total to cover pointer wrap.
